fetch_queue: RTL



---
 rtl/fetch_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 35 +++
 rtl/fetch_queue.sv | 65 ++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of {pc, inst} pairs with occupancy count and synchronous clear
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   wdata,
  output entry_t                   rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !clear) mem[wr_ptr] <= wdata;
  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, drives a req/ack imem port and buffers fetched words
// ahead of the IF/ID registers; redirects flush the buffer and retarget fetch.
module fetch_queue import fetch_pkg::*; #(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic                   imem_ack,
  input  logic [XLEN-1:0]        imem_rdata,
  input  logic                   deq_ready,
  output logic                   deq_valid,
  output logic [XLEN-1:0]        deq_pc,
  output logic [XLEN-1:0]        deq_inst,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state, state_nx;
  logic [XLEN-1:0] fetch_pc, pc_nx, addr_nx, target;
  logic [CW-1:0] count_nx;
  logic free, push, pop, issue, req_nx;
  entry_t head;
  assign target = redirect_pc & ~32'h3;
  assign push = state == WAIT && imem_ack && !redirect_valid;
  assign pop = deq_valid && deq_ready && !redirect_valid;
  // the port is free to carry a new request whenever nothing is outstanding after this cycle
  assign free = state == IDLE || imem_ack;
  always_comb begin
    count_nx = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
    pc_nx = redirect_valid ? target : push ? imem_addr + 32'd4 : fetch_pc;
    issue = free && count_nx < CW'(DEPTH);
    state_nx = issue ? WAIT : free ? IDLE : (redirect_valid && state == WAIT) ? DROP : state;
    req_nx = state_nx != IDLE;
    addr_nx = issue ? pc_nx : imem_addr;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_nx;
      fetch_pc  <= pc_nx;
      imem_req  <= req_nx;
      imem_addr <= addr_nx;
    end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ('{pc: imem_addr, inst: imem_rdata}),
    .rdata (head),
    .count (count)
  );
  assign deq_valid = count != '0;
  assign deq_pc = deq_valid ? head.pc : '0;
  assign deq_inst = deq_valid ? head.inst : NOP_INST;
endmodule
